// File: rtl/vga_grid_capture.sv
// vga_grid_capture: recovers the 4x8 block colour grid from a VGA stream.
// Locks onto hsync/vsync timing and publishes one grid per locked frame.

module vga_grid_capture #(
    parameter int H_TOTAL         = 1040,
    parameter int LINES_PER_FRAME = 665,
    parameter int H_ACT_START     = 188,
    parameter int V_ACT_START     = 31,
    parameter int BLK_W           = 200,
    parameter int BLK_H           = 75,
    parameter int UNDO_OFFSET     = 1
) (
    input  logic        CLK_50M,
    input  logic        RST,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  vga_rgb,
    output logic [23:0] column_0,
    output logic [23:0] column_1,
    output logic [23:0] column_2,
    output logic [23:0] column_3,
    output logic        frame_valid,
    output logic        locked,
    output logic        sync_err
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SAT   = 11'h7ff;
    localparam logic [9:0]  V_SAT   = 10'h3ff;
    localparam logic [10:0] N_LINES = 11'(LINES_PER_FRAME);
    localparam logic [9:0]  V_PUB   = 10'(V_ACT_START + 8 * BLK_H);

    // Colour offset the display adds to each column.
    function automatic logic [2:0] col_off(input int c);
        logic [2:0] o;
        case (c)
            0:       o = 3'd1;
            1:       o = 3'd2;
            2:       o = 3'd4;
            default: o = 3'd6;
        endcase
        if (UNDO_OFFSET == 0) begin
            o = 3'd0;
        end
        return o;
    endfunction

    // Horizontal sample point: centre of block column c.
    function automatic logic [10:0] h_pos(input int c);
        return 11'(H_ACT_START + c * BLK_W + BLK_W / 2);
    endfunction

    // Vertical sample point: centre of block row r.
    function automatic logic [9:0] v_pos(input int r);
        return 10'(V_ACT_START + r * BLK_H + BLK_H / 2);
    endfunction

    logic              hs_q;
    logic              hs_dly_q;
    logic              vs_q;
    logic              vs_dly_q;
    logic [2:0]        rgb_q;

    logic [10:0]       h_cnt_q;
    logic [10:0]       h_cnt_d;
    logic [9:0]        v_cnt_q;
    logic [9:0]        v_cnt_d;

    state_t            state_q;
    state_t            state_d;
    logic              first_q;
    logic              first_d;

    logic [3:0][23:0]  shadow_q;
    logic [3:0][23:0]  shadow_d;
    logic [3:0][23:0]  col_q;
    logic [3:0][23:0]  col_d;
    logic              pub_done_q;
    logic              pub_done_d;

    logic              fv_q;
    logic              fv_d;
    logic              locked_q;
    logic              locked_d;
    logic              err_q;
    logic              err_d;

    logic              hs_fall;
    logic              vs_fall;
    logic [10:0]       lines_seen;
    logic              line_bad;
    logic              frame_bad;
    logic              h_stuck;
    logic              pub_win;
    logic              pub_go;

    // Register the raw VGA inputs plus one extra sync stage for edge detection.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            hs_q     <= 1'b1;
            hs_dly_q <= 1'b1;
            vs_q     <= 1'b1;
            vs_dly_q <= 1'b1;
            rgb_q    <= 3'd0;
        end else begin
            hs_q     <= hsync;
            hs_dly_q <= hs_q;
            vs_q     <= vsync;
            vs_dly_q <= vs_q;
            rgb_q    <= vga_rgb;
        end
    end

    assign hs_fall = hs_dly_q & ~hs_q;
    assign vs_fall = vs_dly_q & ~vs_q;

    // Position counters: h restarts per line, v per frame, both saturate.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (hs_fall) begin
            h_cnt_d = 11'd0;
        end else if (h_cnt_q != H_SAT) begin
            h_cnt_d = h_cnt_q + 11'd1;
        end
        if (vs_fall) begin
            v_cnt_d = 10'd0;
        end else if (hs_fall && (v_cnt_q != V_SAT)) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end
    end

    // A coincident hsync edge still belongs to the frame that is ending.
    assign lines_seen = {1'b0, v_cnt_q} + {10'd0, hs_fall};
    assign line_bad   = hs_fall & ~first_q & (h_cnt_q != H_LAST);
    assign frame_bad  = vs_fall & (lines_seen != N_LINES);
    assign h_stuck    = (h_cnt_q == H_SAT);

    // Lock state register.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock next-state: one good frame in VERIFY earns LOCKED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (line_bad) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    state_d = frame_bad ? SEARCH : LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad || h_stuck) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Lock outputs: level while LOCKED, pulse when LOCKED is lost.
    always_comb begin
        locked_d = (state_d == LOCKED);
        err_d    = (state_q == LOCKED) && (state_d != LOCKED);
    end

    // The first line after leaving SEARCH has an unknown start, so skip it.
    always_comb begin
        first_d = first_q;
        if ((state_q == SEARCH) && (state_d == VERIFY)) begin
            first_d = 1'b1;
        end else if (hs_fall) begin
            first_d = 1'b0;
        end
    end

    // Shadow grid: cleared per frame, one cell written at each block centre.
    always_comb begin
        shadow_d = shadow_q;
        if (vs_fall) begin
            shadow_d = '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 8; r++) begin
                    if ((h_cnt_q == h_pos(c)) && (v_cnt_q == v_pos(r))) begin
                        shadow_d[c][3 * (7 - r) +: 3] = rgb_q - col_off(c);
                    end
                end
            end
        end
    end

    // Publish once per frame, just below the active area, only while locked.
    always_comb begin
        pub_win    = (v_cnt_q == V_PUB) && (h_cnt_q == 11'd0);
        pub_go     = pub_win && !pub_done_q &&
                     (state_q == LOCKED) && (state_d == LOCKED);
        pub_done_d = pub_done_q;
        if (vs_fall) begin
            pub_done_d = 1'b0;
        end else if (pub_win) begin
            pub_done_d = 1'b1;
        end
        col_d = pub_go ? shadow_q : col_q;
        fv_d  = pub_go;
    end

    // Counters, capture storage and registered outputs.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            h_cnt_q    <= 11'd0;
            v_cnt_q    <= 10'd0;
            first_q    <= 1'b0;
            shadow_q   <= '0;
            col_q      <= '0;
            pub_done_q <= 1'b0;
            fv_q       <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            first_q    <= first_d;
            shadow_q   <= shadow_d;
            col_q      <= col_d;
            pub_done_q <= pub_done_d;
            fv_q       <= fv_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign column_0    = col_q[0];
    assign column_1    = col_q[1];
    assign column_2    = col_q[2];
    assign column_3    = col_q[3];
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_vga_grid_capture.sv
// tb_vga_grid_capture: drives a scaled VGA block display into the capture
// block; a monitor scores published grids against an expected-frame queue.

module tb_vga_grid_capture;

    localparam int HT  = 50;
    localparam int LPF = 40;
    localparam int HA  = 6;
    localparam int VA  = 3;
    localparam int BW  = 10;
    localparam int BH  = 4;
    localparam int HSW = 4;

    typedef logic [3:0][23:0] grid_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs  = 1'b1;
    logic        vs  = 1'b1;
    logic [2:0]  rgb = 3'd0;

    logic [23:0] c0, c1, c2, c3;
    logic        fv, lk, se;
    logic [23:0] r0, r1, r2, r3;
    logic        rfv, rlk, rse;

    vga_grid_capture #(
        .H_TOTAL(HT), .LINES_PER_FRAME(LPF), .H_ACT_START(HA),
        .V_ACT_START(VA), .BLK_W(BW), .BLK_H(BH), .UNDO_OFFSET(1)
    ) u_dut (
        .CLK_50M(clk), .RST(rst), .hsync(hs), .vsync(vs), .vga_rgb(rgb),
        .column_0(c0), .column_1(c1), .column_2(c2), .column_3(c3),
        .frame_valid(fv), .locked(lk), .sync_err(se)
    );

    vga_grid_capture #(
        .H_TOTAL(HT), .LINES_PER_FRAME(LPF), .H_ACT_START(HA),
        .V_ACT_START(VA), .BLK_W(BW), .BLK_H(BH), .UNDO_OFFSET(0)
    ) u_raw (
        .CLK_50M(clk), .RST(rst), .hsync(hs), .vsync(vs), .vga_rgb(rgb),
        .column_0(r0), .column_1(r1), .column_2(r2), .column_3(r3),
        .frame_valid(rfv), .locked(rlk), .sync_err(rse)
    );

    always #5 clk = ~clk;

    int    n_pass     = 0;
    int    n_chk      = 0;
    int    err_cnt    = 0;
    int    good_edges = 0;
    int    OFF[4]     = '{1, 2, 4, 6};
    grid_t sb_q[$];
    grid_t sbr_q[$];
    grid_t last_pub   = '0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Displayed colour of pixel x on line ln for source grid w.
    function automatic logic [2:0] pix(grid_t w, int x, int ln);
        int c;
        int r;
        logic [2:0] v;
        if (x < HA || x >= HA + 4 * BW || ln < VA || ln >= VA + 8 * BH)
            return 3'd0;
        c = (x - HA) / BW;
        r = (ln - VA) / BH;
        v = w[c][(7 - r) * 3 +: 3];
        return v + 3'(OFF[c]);
    endfunction

    // Grid as seen on the wire: every cell carries its column offset.
    function automatic grid_t raw_grid(grid_t w);
        grid_t o;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 8; k++)
                o[c][k * 3 +: 3] = w[c][k * 3 +: 3] + 3'(OFF[c]);
        return o;
    endfunction

    function automatic grid_t rand_grid();
        grid_t g;
        for (int c = 0; c < 4; c++) g[c] = 24'($urandom);
        return g;
    endfunction

    task automatic step(input logic h, input logic v, input logic [2:0] p);
        @(posedge clk);
        #1;
        hs  = h;
        vs  = v;
        rgb = p;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_col0"}, 32'(c0), 0);
        check({tag, "_col1"}, 32'(c1), 0);
        check({tag, "_col2"}, 32'(c2), 0);
        check({tag, "_col3"}, 32'(c3), 0);
        check({tag, "_fv"}, 32'(fv), 0);
        check({tag, "_locked"}, 32'(lk), 0);
        check({tag, "_sync_err"}, 32'(se), 0);
        check({tag, "_raw_col0"}, 32'(r0), 0);
    endtask

    // mode 0 clean, 1 one long line, 2 hsync stalls, 3 reset pulse mid-frame
    task automatic run_frame(input grid_t w, input int mode);
        bit    pub;
        bit    was_lk;
        int    e0;
        int    xn;
        grid_t cur;
        good_edges++;
        was_lk = (good_edges >= 2);
        pub    = was_lk && (mode == 0);
        e0     = err_cnt;
        if (pub) begin
            sb_q.push_back(w);
            sbr_q.push_back(raw_grid(w));
        end
        for (int ln = 0; ln < LPF; ln++) begin
            if (mode == 2 && ln == 12) begin
                repeat (2200) step(1'b1, 1'b1, 3'd0);
                break;
            end
            xn = (mode == 1 && ln == 10) ? HT + 1 : HT;
            for (int x = 0; x < xn; x++) begin
                step(x < HSW ? 1'b0 : 1'b1, ln < 2 ? 1'b0 : 1'b1,
                     x < HT ? pix(w, x, ln) : 3'd0);
                if (rst) begin
                    check_zero("after_rst");
                    rst = 1'b0;
                end
                if (mode == 3 && ln == 15 && x == 20) rst = 1'b1;
            end
            if (ln == 1) check("locked_early", 32'(lk), 32'(was_lk));
        end
        check("locked_end", 32'(lk), 32'(pub));
        check("publish_pending", 32'(sb_q.size()), 0);
        check("raw_publish_pending", 32'(sbr_q.size()), 0);
        check("sync_err_pulses", 32'(err_cnt - e0),
              32'((mode == 1 || mode == 2) && was_lk));
        if (pub) last_pub = w;
        if (mode == 3) last_pub = '0;
        cur = {c3, c2, c1, c0};
        for (int i = 0; i < 4; i++)
            check($sformatf("hold_col%0d", i), 32'(cur[i]), 32'(last_pub[i]));
        if (mode != 0) good_edges = 0;
    endtask

    // Monitor: score every publish, flag column changes outside publish/reset.
    initial begin
        grid_t prev = '0;
        grid_t cur;
        grid_t rc;
        grid_t e;
        logic  rst_e;
        forever begin
            @(posedge clk);
            rst_e = rst;
            @(negedge clk);
            cur = {c3, c2, c1, c0};
            rc  = {r3, r2, r1, r0};
            if (fv) begin
                check("pub_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    for (int i = 0; i < 4; i++)
                        check($sformatf("column_%0d", i), 32'(cur[i]), 32'(e[i]));
                end
            end
            if (rfv) begin
                check("raw_pub_expected", 32'(sbr_q.size() > 0), 1);
                if (sbr_q.size() > 0) begin
                    e = sbr_q.pop_front();
                    for (int i = 0; i < 4; i++)
                        check($sformatf("raw_column_%0d", i), 32'(rc[i]), 32'(e[i]));
                end
            end
            if (cur != prev) check("cols_change_at_publish", 32'(fv | rst_e), 1);
            prev = cur;
            if (se) err_cnt++;
        end
    end

    initial begin
        grid_t w0;
        grid_t w;
        w0[0] = 24'o01234567;
        w0[1] = 24'o76543210;
        w0[2] = 24'o0;
        w0[3] = 24'o77777777;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        repeat (5) step(1'b1, 1'b1, 3'd0);
        repeat (4) run_frame(w0, 0);
        w = w0;
        w[2] = 24'($urandom);
        run_frame(w, 0);
        w[2] = 24'($urandom);
        run_frame(w, 0);
        run_frame('0, 0);
        run_frame(rand_grid(), 0);
        w = rand_grid();
        run_frame(w, 1);
        run_frame(w, 0);
        run_frame(w, 0);
        w = rand_grid();
        run_frame(w, 2);
        run_frame(w, 0);
        run_frame(w, 0);
        w = rand_grid();
        run_frame(w, 3);
        run_frame(w, 0);
        run_frame(w, 0);
        repeat (10) step(1'b1, 1'b1, 3'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_grid_capture.md
Name: vga_grid_capture

Overview:
- Receive end of the team's 800x600 VGA block display: consumes hsync, vsync and 3-bit rgb on the 50 MHz pixel clock and recovers the 4-column x 8-row colour grid.
- Outputs the grid as four packed 24-bit column words, in the same format the display controller accepts.
- Used as a loopback checker and frame monitor, so that displayed frames can be compared against the game-state columns.

Parameters:
- H_TOTAL, 1040, clocks between consecutive hsync falling edges.
- LINES_PER_FRAME, 665, hsync falling edges between consecutive vsync falling edges.
- H_ACT_START, 188, h_cnt value of the first active pixel.
- V_ACT_START, 31, v_cnt value of the first active line.
- BLK_W, 200, block width in pixels (4 columns, active width 4*BLK_W).
- BLK_H, 75, block height in lines (8 rows, active height 8*BLK_H).
- UNDO_OFFSET, 1, when 1, subtract the per-column colour offsets 1, 2, 4, 6 (mod 8) from each sample.

Ports:
- CLK_50M  in  1  pixel/system clock.
- RST  in  1  synchronous, active-high reset.
- hsync  in  1  VGA horizontal sync, active low.
- vsync  in  1  VGA vertical sync, active low.
- vga_rgb  in  3  pixel colour {R,G,B}.
- column_0..column_3  out  24 each  captured grid; row r occupies bits [(7-r)*3+2:(7-r)*3], so row 0 is [23:21].
- frame_valid  out  1  one-cycle pulse when column_* has been updated.
- locked  out  1  timing lock indicator.
- sync_err  out  1  one-cycle pulse on a timing violation while LOCKED.

Behaviour:
- Reset: all outputs 0; state SEARCH; h_cnt 0, v_cnt 0.
- Input registering: hsync, vsync and vga_rgb pass through one register stage. All logic below uses the registered copies; edges are detected against a second delayed copy.
- h_cnt (11 bit):
  - cleared to 0 on the cycle an hsync falling edge is detected;
  - otherwise increments, saturating at 2047.
- v_cnt (10 bit):
  - cleared on a vsync falling edge;
  - otherwise incremented on each hsync falling edge, saturating at 1023;
  - if both edges occur in the same cycle, vsync wins and v_cnt becomes 0.
- Line check: at each hsync falling edge the previous h_cnt must equal H_TOTAL-1. The first edge after leaving SEARCH is exempt.
- Frame check: at each vsync falling edge the number of hsync edges counted since the previous vsync edge must equal LINES_PER_FRAME.
- State machine:
  - SEARCH: go to VERIFY on a vsync falling edge.
  - VERIFY: any line-check failure returns to SEARCH. At the next vsync edge, a passing frame check goes to LOCKED; a failing one goes to SEARCH.
  - LOCKED: any line-check or frame-check failure, or h_cnt reaching saturation, goes to SEARCH with sync_err=1 for one cycle.
  - locked=1 exactly while in LOCKED.
- Sampling: a sample is taken when h_cnt == H_ACT_START + c*BLK_W + BLK_W/2 and v_cnt == V_ACT_START + r*BLK_H + BLK_H/2, for c in 0..3 and r in 0..7.
  - Sample value = registered vga_rgb, minus offset[c] mod 8 when UNDO_OFFSET=1.
  - The sample is written into a shadow cell (c, r). Shadow registers are cleared at each vsync falling edge.
- Publish: on the first cycle with v_cnt == V_ACT_START + 8*BLK_H and h_cnt == 0:
  - only if the state has been LOCKED continuously since the last vsync edge, copy shadow to column_* and pulse frame_valid for one cycle;
  - otherwise column_* is held and there is no pulse.
  - column_* changes only at a publish or on reset.
- Loss of lock mid-frame suppresses that frame's publish.
- Reset asserted mid-frame returns to the reset state on the next clock; the previous column_* values are cleared.
- Arithmetic: comparisons use 11-bit h and 10-bit v; offset subtraction is a 3-bit wrap.

Test Plan:
- Bit-accurate display timing model with columns 24'o01234567, 24'o76543210, 24'o0, 24'o77777777, colour = cell + {1,2,4,6}:
  - locked rises at the 2nd vsync falling edge;
  - first frame_valid comes on the following frame with column_0..3 equal to the source words;
  - exactly one pulse per frame thereafter.
- UNDO_OFFSET=0 with all cells 0: captured columns are 24'o11111111, 24'o22222222, 24'o44444444, 24'o66666666.
- Stretch one line to 1041 clocks while LOCKED:
  - sync_err pulses once and locked drops;
  - that frame is not published and column_* holds;
  - relock happens two vsync edges later.
- Stop hsync toggling: h_cnt saturates at 2047, sync_err pulses, and there is no further frame_valid.
- Change column_2 between frames: the next publish reflects the new value and no intermediate value appears.
- Assert RST for one cycle mid-active area: all outputs are 0 next cycle, and the lock sequence restarts from SEARCH.
